// File: rtl/gerenciador_estados.sv
// Main pet state controller: one-hot pet state updated once per decision tick
// from two buttons and packed status channels. Optional ALERTA_EN builds low-status flags.
module gerenciador_estados #(
  parameter int N_STATUS      = 3,
  parameter int STATUS_W      = 8,
  parameter int TICK_PERIOD   = 4194304,
  parameter int HOLD_CYCLES   = 134217728,
  parameter int MORTE_LIMIAR  = 0,
  parameter int ATIV_TICKS    = 8,
  parameter int ALERTA_LIMIAR = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         b1,
  input  logic                         b2,
  input  logic                         b1_hold,
  input  logic                         b2_hold,
  input  logic [N_STATUS*STATUS_W-1:0] status,
  output logic [4:0]                   estado,
  output logic                         tick,
  output logic [N_STATUS-1:0]          alerta
);

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;

  localparam int TW = $clog2(TICK_PERIOD);
  localparam int AW = (ATIV_TICKS == 0) ? 1 : $clog2(ATIV_TICKS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [AW-1:0]       ATIV_LAST = (ATIV_TICKS == 0) ? '0 : AW'(ATIV_TICKS - 1);
  localparam logic [HW-1:0]       HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [STATUS_W-1:0] MORTE_V   = STATUS_W'(MORTE_LIMIAR);

  estado_t       estado_q, estado_nxt;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] ativ_cnt, ativ_nxt;
  logic [HW-1:0] hold_cnt;
  logic          b1_l, b2_l;
  logic          decisao, hold_both, hold_fire, eb1, eb2, morte;

  function automatic logic morte_det(input logic [N_STATUS*STATUS_W-1:0] s);
    morte_det = 1'b0;
    for (int i = 0; i < N_STATUS; i++)
      if (s[i*STATUS_W +: STATUS_W] <= MORTE_V) morte_det = 1'b1;
  endfunction

  assign decisao   = (tick_cnt == TICK_LAST);
  assign hold_both = b1_hold & b2_hold;
  // Fires on the edge the counter reaches HOLD_CYCLES and every cycle while saturated.
  assign hold_fire = hold_both & (hold_cnt >= HOLD_LAST);
  assign eb1       = b1_l | b1;
  assign eb2       = b2_l | b2;
  assign morte     = morte_det(status);
  assign estado    = estado_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= INTRO;
      tick     <= 1'b0;
      tick_cnt <= '0;
      ativ_cnt <= '0;
      hold_cnt <= '0;
      b1_l     <= 1'b0;
      b2_l     <= 1'b0;
    end else begin
      estado_q <= estado_nxt;
      ativ_cnt <= ativ_nxt;
      tick     <= decisao;
      if (!hold_both)               hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      if (hold_fire || decisao) begin
        tick_cnt <= hold_fire ? '0 : (decisao ? '0 : tick_cnt + TW'(1));
        b1_l     <= 1'b0;
        b2_l     <= 1'b0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
        b1_l     <= b1_l | b1;
        b2_l     <= b2_l | b2;
      end
    end
  end

  always_comb begin
    estado_nxt = estado_q;
    ativ_nxt   = ativ_cnt;
    if (decisao) begin
      ativ_nxt = '0;
      if (estado_q == MORTO || morte) begin
        estado_nxt = MORTO;
      end else begin
        case (estado_q)
          INTRO: if (eb1 | eb2) estado_nxt = IDLE;
          IDLE: begin
            if (eb1 & eb2)       estado_nxt = DANDO_AULA;
            else if (eb1)        estado_nxt = COMENDO;
            else if (eb2)        estado_nxt = DORMINDO;
          end
          DORMINDO, COMENDO, DANDO_AULA: begin
            if (eb1 | eb2)                                      estado_nxt = IDLE;
            else if ((ATIV_TICKS != 0) && (ativ_cnt == ATIV_LAST)) estado_nxt = IDLE;
            else if (ATIV_TICKS != 0)                           ativ_nxt = ativ_cnt + AW'(1);
          end
          default: estado_nxt = INTRO;
        endcase
      end
    end
    if (hold_fire) begin
      estado_nxt = INTRO;
      ativ_nxt   = '0;
    end
  end

`ifdef ALERTA_EN
  localparam logic [STATUS_W:0] ALERTA_V = (STATUS_W + 1)'(ALERTA_LIMIAR);
  logic [N_STATUS-1:0] alerta_q, alerta_nxt;

  always_comb begin
    alerta_nxt = '0;
    for (int i = 0; i < N_STATUS; i++)
      alerta_nxt[i] = ({1'b0, status[i*STATUS_W +: STATUS_W]} < ALERTA_V);
    if (estado_nxt == MORTO) alerta_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            alerta_q <= '0;
    else if (hold_fire) alerta_q <= '0;
    else if (decisao)   alerta_q <= alerta_nxt;
  end

  assign alerta = alerta_q;
`else
  logic alerta_unused;
  assign alerta_unused = (ALERTA_LIMIAR != 0);
  assign alerta = '0;
`endif

endmodule

// File: tb/tb_gerenciador_estados.sv
// Directed self-checking bench for gerenciador_estados (TICK_PERIOD=4, HOLD_CYCLES=8, ATIV_TICKS=3).
module tb_gerenciador_estados;

  localparam logic [4:0] S_INTRO = 5'b00000;
  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_DORM  = 5'b00010;
  localparam logic [4:0] S_COME  = 5'b00100;
  localparam logic [4:0] S_AULA  = 5'b01000;
  localparam logic [4:0] S_MORTO = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b1 = 1'b0, b2 = 1'b0, b1_hold = 1'b0, b2_hold = 1'b0;
  logic [23:0] status = {8'd100, 8'd100, 8'd100};
  logic [4:0]  estado;
  logic        tick;
  logic [2:0]  alerta;
  int          tests = 0;
  int          fails = 0;

  gerenciador_estados #(
    .N_STATUS(3), .STATUS_W(8), .TICK_PERIOD(4), .HOLD_CYCLES(8),
    .MORTE_LIMIAR(0), .ATIV_TICKS(3), .ALERTA_LIMIAR(32)
  ) dut (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .b1_hold(b1_hold), .b2_hold(b2_hold),
    .status(status), .estado(estado), .tick(tick), .alerta(alerta)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    b1 = 1'b1;
    cyc(3);
    tests++; if (estado !== S_INTRO) begin fails++; $display("FAIL reset_estado: got %b want %b", estado, S_INTRO); end
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", tick); end
    tests++; if (alerta !== 3'b000) begin fails++; $display("FAIL reset_alerta: got %b want 000", alerta); end
    b1 = 1'b0;
  endtask

  task automatic test_intro();
    rst = 1'b0;                // cycle 0
    cyc(1); b1 = 1'b1;         // cycle 1
    cyc(1); b1 = 1'b0;         // cycle 2
    cyc(1);                    // cycle 3, decision
    tests++; if (tick !== 1'b0 || estado !== S_INTRO) begin fails++; $display("FAIL intro_pre: got tick=%b estado=%b want tick=0 estado=%b", tick, estado, S_INTRO); end
    cyc(1);                    // cycle 4
    tests++; if (tick !== 1'b1) begin fails++; $display("FAIL intro_tick: got %b want 1", tick); end
    tests++; if (estado !== S_IDLE) begin fails++; $display("FAIL intro_idle: got %b want %b", estado, S_IDLE); end
    cyc(1);
    tests++; if (tick !== 1'b0 || estado !== S_IDLE) begin fails++; $display("FAIL intro_post: got tick=%b estado=%b want tick=0 estado=%b", tick, estado, S_IDLE); end
    cyc(3);
  endtask

  task automatic test_idle_buttons();
    b1 = 1'b1;
    cyc(1); b1 = 1'b0; b2 = 1'b1;
    cyc(1); b2 = 1'b0;
    cyc(2);
    tests++; if (tick !== 1'b1 || estado !== S_AULA) begin fails++; $display("FAIL aula: got tick=%b estado=%b want tick=1 estado=%b", tick, estado, S_AULA); end
    cyc(3); b1 = 1'b1;
    cyc(1); b1 = 1'b0;
    tests++; if (estado !== S_IDLE) begin fails++; $display("FAIL aula_exit: got %b want %b", estado, S_IDLE); end
    cyc(3); b2 = 1'b1;         // only in the decision cycle
    cyc(1); b2 = 1'b0;
    tests++; if (estado !== S_DORM) begin fails++; $display("FAIL dormindo: got %b want %b", estado, S_DORM); end
    cyc(3); b1 = 1'b1;
    cyc(1); b1 = 1'b0;
    tests++; if (estado !== S_IDLE) begin fails++; $display("FAIL dorm_exit: got %b want %b", estado, S_IDLE); end
  endtask

  task automatic test_timeout();
    cyc(3); b1 = 1'b1;
    cyc(1); b1 = 1'b0;
    tests++; if (estado !== S_COME) begin fails++; $display("FAIL comendo: got %b want %b", estado, S_COME); end
    cyc(2);
    tests++; if (estado !== S_COME || tick !== 1'b0) begin fails++; $display("FAIL between_ticks: got tick=%b estado=%b want tick=0 estado=%b", tick, estado, S_COME); end
    cyc(2);
    tests++; if (estado !== S_COME) begin fails++; $display("FAIL timeout_t1: got %b want %b", estado, S_COME); end
    cyc(4);
    tests++; if (estado !== S_COME) begin fails++; $display("FAIL timeout_t2: got %b want %b", estado, S_COME); end
    cyc(4);
    tests++; if (estado !== S_IDLE) begin fails++; $display("FAIL timeout_t3: got %b want %b", estado, S_IDLE); end
    cyc(3); b1 = 1'b1;
    cyc(1); b1 = 1'b0;
    cyc(4);
    tests++; if (estado !== S_COME) begin fails++; $display("FAIL early_t1: got %b want %b", estado, S_COME); end
    cyc(3); b2 = 1'b1;
    cyc(1); b2 = 1'b0;
    tests++; if (estado !== S_IDLE) begin fails++; $display("FAIL early_t2: got %b want %b", estado, S_IDLE); end
  endtask

  task automatic test_morte();
    status = {8'd0, 8'd100, 8'd100};
    cyc(4);
    tests++; if (estado !== S_MORTO) begin fails++; $display("FAIL morte: got %b want %b", estado, S_MORTO); end
    tests++; if (alerta !== 3'b000) begin fails++; $display("FAIL morte_alerta: got %b want 000", alerta); end
    status = {8'd100, 8'd100, 8'd100};
    for (int t = 0; t < 10; t++) begin
      b1 = 1'b1; b2 = (t % 2) == 1;
      cyc(1); b1 = 1'b0; b2 = 1'b0;
      cyc(3);
      tests++; if (estado !== S_MORTO || tick !== 1'b1) begin fails++; $display("FAIL morte_hold t=%0d: got tick=%b estado=%b want tick=1 estado=%b", t, tick, estado, S_MORTO); end
    end
  endtask

  task automatic test_hold();
    b1_hold = 1'b1; b2_hold = 1'b1;
    cyc(7);
    tests++; if (estado !== S_MORTO) begin fails++; $display("FAIL hold_edge7: got %b want %b", estado, S_MORTO); end
    cyc(1);                    // 8th edge coincides with a decision
    tests++; if (estado !== S_INTRO) begin fails++; $display("FAIL hold_edge8: got %b want %b", estado, S_INTRO); end
    tests++; if (tick !== 1'b1) begin fails++; $display("FAIL hold_tick: got %b want 1", tick); end
    for (int c = 0; c < 10; c++) begin
      b1 = (c % 3) == 0;
      cyc(1);
      tests++; if (estado !== S_INTRO || tick !== 1'b0) begin fails++; $display("FAIL hold_held c=%0d: got tick=%b estado=%b want tick=0 estado=%b", c, tick, estado, S_INTRO); end
    end
    b1 = 1'b0; b1_hold = 1'b0; b2_hold = 1'b0;
    b1 = 1'b1;                 // cycle 0 after release
    cyc(1); b1 = 1'b0;
    cyc(2);
    tests++; if (estado !== S_INTRO || tick !== 1'b0) begin fails++; $display("FAIL release_pre: got tick=%b estado=%b want tick=0 estado=%b", tick, estado, S_INTRO); end
    cyc(1);
    tests++; if (estado !== S_IDLE || tick !== 1'b1) begin fails++; $display("FAIL release_idle: got tick=%b estado=%b want tick=1 estado=%b", tick, estado, S_IDLE); end
  endtask

  task automatic test_alerta();
    logic [2:0] exp_low;
`ifdef ALERTA_EN
    exp_low = 3'b001;
`else
    exp_low = 3'b000;
`endif
    status = {8'd100, 8'd100, 8'd31};
    cyc(3);
    tests++; if (alerta !== 3'b000) begin fails++; $display("FAIL alerta_pre: got %b want 000", alerta); end
    cyc(1);
    tests++; if (alerta !== exp_low) begin fails++; $display("FAIL alerta_31: got %b want %b", alerta, exp_low); end
    status = {8'd100, 8'd100, 8'd32};
    cyc(3);
    tests++; if (alerta !== exp_low) begin fails++; $display("FAIL alerta_held: got %b want %b", alerta, exp_low); end
    cyc(1);
    tests++; if (alerta !== 3'b000) begin fails++; $display("FAIL alerta_32: got %b want 000", alerta); end
    status = {8'd100, 8'd100, 8'd31};
    cyc(4);
    tests++; if (alerta !== exp_low) begin fails++; $display("FAIL alerta_again: got %b want %b", alerta, exp_low); end
  endtask

  task automatic test_async_reset();
    b1 = 1'b1;
    cyc(2); #2;
    rst = 1'b1;
    #1;
    tests++; if (estado !== S_INTRO || tick !== 1'b0 || alerta !== 3'b000) begin fails++; $display("FAIL async_rst: got estado=%b tick=%b alerta=%b want %b 0 000", estado, tick, alerta, S_INTRO); end
    b1 = 1'b0;
    cyc(2);
    tests++; if (estado !== S_INTRO || tick !== 1'b0) begin fails++; $display("FAIL rst_held: got tick=%b estado=%b want tick=0 estado=%b", tick, estado, S_INTRO); end
  endtask

  initial begin
    test_reset();
    test_intro();
    test_idle_buttons();
    test_timeout();
    test_morte();
    test_hold();
    test_alerta();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gerenciador_estados.md
Name: gerenciador_estados

Overview:
Parametrised successor to the Tamagotchi main state controller. Tracks pet state (INTRO, IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO) from two buttons and N packed status channels, evaluating transitions once per periodic decision tick. Beyond the previous controller, it adds:
- configurable tick period, hold-reset time, status count/width and death threshold
- same-cycle button capture at the tick
- automatic activity timeout back to IDLE
- async reset

It sits between the button debouncers/status counters and the display/sprite logic.

Parameters:
N_STATUS, 3, number of status channels (fome, felicidade, sono, ...)
STATUS_W, 8, bits per status channel
TICK_PERIOD, 4194304, clk cycles per decision tick (>=2)
HOLD_CYCLES, 134217728, cycles both holds must be asserted to force INTRO (>=1)
MORTE_LIMIAR, 0, status value <= this at a tick kills the pet
ATIV_TICKS, 8, ticks an activity lasts before auto-return to IDLE; 0 = never
ALERTA_LIMIAR, 32, status value < this raises alerta (optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
b1, b2  in  1  button press pulses/levels
b1_hold, b2_hold  in  1  long-press indicators
status  in  N_STATUS*STATUS_W  packed status; channel i = bits [i*STATUS_W +: STATUS_W]
estado  out  5  one-hot state: INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000
tick  out  1  one-cycle pulse in the decision cycle
alerta  out  N_STATUS  per-channel low-status flags

Behaviour:
- Reset (rst high, async): estado=INTRO, tick=0, alerta=0, tick counter=0, button latches=0, hold counter=0, activity counter=0. All state is held while rst is high.
- Tick counter: 0..TICK_PERIOD-1, wraps to 0. tick=1 (registered) in the cycle after the counter equals TICK_PERIOD-1, so the first tick comes TICK_PERIOD cycles after reset release.
- Decision cycle: the cycle in which the counter equals TICK_PERIOD-1. estado updates at the following edge, aligned with tick.
- Button latches b1_l/b2_l: set by b1/b2 in any cycle. At a decision cycle the effective value is eb = b_l | b (a press in the decision cycle itself counts). The latches clear at that edge.
- Transitions at a decision cycle, in priority order:
  1. estado==MORTO, or any channel <= MORTE_LIMIAR (unsigned) -> MORTO. This applies in every state, including INTRO.
  2. INTRO: eb1|eb2 -> IDLE; else stay.
  3. IDLE: eb1&!eb2 -> COMENDO; !eb1&eb2 -> DORMINDO; eb1&eb2 -> DANDO_AULA; else stay.
  4. Activity states: eb1|eb2 -> IDLE. Else if ATIV_TICKS!=0 and the activity counter == ATIV_TICKS-1 -> IDLE. Else stay and increment the counter.
- Activity counter: cleared on every entry to an activity state and on leaving one. Width is clog2(ATIV_TICKS+1), minimum 1 bit.
- Hold reset:
  - The hold counter increments each cycle b1_hold&b2_hold is high and saturates at HOLD_CYCLES; it clears to 0 in any cycle either hold is low.
  - When the counter is saturated, or reaches HOLD_CYCLES at this edge: estado<=INTRO, latches and activity counter clear, tick counter<=0.
  - This overrides the decision logic, including MORTO. INTRO is held until release; normal ticking resumes from 0 after release.
- Hold reset and decision in the same cycle: hold wins, and tick is still pulsed.
- No other outputs change between ticks; estado is only ever one of the six legal codes.

Optional Feature:
ALERTA_EN:
- Defined: at each decision cycle, alerta[i] <= (channel i < ALERTA_LIMIAR) and estado will not be MORTO. alerta holds between ticks and is cleared by rst or hold reset.
- Undefined: alerta is tied to 0 and no comparators are built.

Test Plan:
- N_STATUS=3, STATUS_W=8, TICK_PERIOD=4, HOLD_CYCLES=8, ATIV_TICKS=3, statuses all 100. Release rst, pulse b1 at cycle 1 -> tick at cycle 4, estado INTRO->IDLE at that edge.
- From IDLE, b1 and b2 pulsed in different cycles within one tick window -> DANDO_AULA at the next tick. b2 alone, asserted only in the decision cycle -> DORMINDO.
- From COMENDO with no buttons -> still COMENDO after ticks 1 and 2, IDLE on tick 3. A button at tick 2 -> IDLE at tick 2.
- From IDLE, set channel 2 to 0 -> MORTO at the next tick. Buttons then have no effect for 10 ticks.
- From MORTO, assert b1_hold&b2_hold for 8 cycles -> estado=INTRO on the 8th edge, held while asserted. After release, b1 -> IDLE at the next tick (TICK_PERIOD cycles later).
- With ALERTA_EN defined, ALERTA_LIMIAR=32, channel 0 = 31 and others 100 -> alerta=001 after the tick. Channel 0 = 32 -> alerta=000 at the next tick. Assert rst mid-window -> all outputs at reset values immediately.
